cdc_hs_rx: RTL and testbench
============================

Name: cdc_hs_rx

Overview:
- Receive side of a four-phase req/ack clock-domain crossing for a W-bit word, e.g. corner-detector configuration or statistics words.
- Takes the sender's raw req and a bus the sender holds stable; req is synchronized internally with the team's two-flop synchronizer `s`.
- Captures the word and presents it on a local valid/ready interface.
- Returns ack to the sender domain, where the sender synchronizes it back with its own `s` instance.

Parameters:
W, 32, data bus width
CW, 16, width of the transfer counter

Ports:
c  input  1  clock, local domain
rst  input  1  reset, asynchronous, active-high
req  input  1  sender request, asynchronous to c
d  input  W  sender data; stable from before req rises until sender sees ack
ack  output  1  acknowledge to sender domain, driven directly by a flop
q  output  W  captured word
q_valid  output  1  q holds an unconsumed word
q_ready  input  1  consumer accepts q when q_valid&q_ready
err  output  1  sticky protocol-error flag
err_clr  input  1  synchronous clear of err
xfer_cnt  output  CW  count of completed transfers

Behaviour:
- One clock c. Reset rst is asynchronous and active-high.
- Reset values: ack=0, q=0, q_valid=0, err=0, xfer_cnt=0, FSM=IDLE.
- The `s` flops are not reset.
- req_s is the output of s #(.W(1)) on req. It lags req by 2 edges.
- IDLE: ack=0, q_valid=0. If req_s=1, then at that edge: q<=d, q_valid<=1, go HOLD.
- HOLD: q_valid=1, q stable. On q_valid&q_ready: q_valid<=0, ack<=1, xfer_cnt<=xfer_cnt+1 (wraps modulo 2^CW), go ACK.
- ACK: ack=1. When req_s=0: ack<=0, go IDLE.
- The next capture needs req_s=1 seen in IDLE, so a new word is never taken while ack=1.
- Latency:
  - req first sampled high at edge N gives q_valid=1 after edge N+2.
  - Accept at edge M gives ack=1 after edge M.
  - req low sampled at edge K gives ack=0 after edge K+2.
- q_ready is ignored while q_valid=0. q_ready may be held high permanently; the accept then happens on the first HOLD cycle.
- Protocol error: req_s=0 while in HOLD (sender dropped req before ack). Then err<=1 and the transfer still completes normally. ACK then sees req_s=0 and drops ack one cycle after entering ACK.
- err_clr=1 clears err unless a new error is detected in the same cycle; a new error wins.
- d is sampled only in the IDLE->HOLD cycle. Changes to d at any other time have no effect on q.
- Reset mid-transfer: all outputs return to reset values immediately (async assert), including the q_valid word being discarded. The system applies rst to sender and receiver domains together. The block does not recover a transfer orphaned by a one-sided reset.
- Reset deassertion: the FSM leaves IDLE only on a c edge after rst is low.

Decomposition:
- Shared include cdc_defs.vh holds the state encodings ST_IDLE=2'd0, ST_HOLD=2'd1, ST_ACK=2'd2. The sender side (cdc_hs_tx) uses the same include.
- The one sub-module is the existing synchronizer `s`, instantiated once for req.
- The FSM, capture register and counter are flat in cdc_hs_rx.

Test Plan:
- Basic transfer, q_ready tied 1: d=32'hDEADBEEF, req rises at cycle 10.
  - Required: q=DEADBEEF and q_valid high for exactly one cycle after edge 12, ack=1 from edge 13.
  - Drop req at cycle 20: ack=0 after edge 22, xfer_cnt=1.
- Backpressure: q_ready=0 for 20 cycles after capture.
  - Required: q_valid holds, q stable even if d is changed to 0x12345678, ack stays 0.
  - Required: ack rises the edge after q_ready=1.
- Back-to-back: 300 sender-model transfers with incrementing data and random q_ready.
  - Required: all words received in order with no duplicates.
  - Required: xfer_cnt=300 with CW=16, and xfer_cnt wraps to 0 after 2^CW transfers with CW=4.
- Protocol error: drop req during HOLD (q_ready=0).
  - Required: err=1 next cycle; word still delivered; ack pulses one cycle.
  - Required: err_clr=1 clears err; err_clr together with a new error leaves err=1.
- Async reset: assert rst mid-cycle in HOLD with q_valid=1.
  - Required: q_valid, ack, q and xfer_cnt go to 0 without waiting for an edge.
  - Required: after release with req low, the next transfer completes normally.
- Asynchronous req: randomize the req edge phase against c.
  - Required: capture latency is always 2–3 cycles.
  - Required: data integrity holds across 1000 transfers.

Source files
------------

// File: rtl/cdc_hs_rx_pkg.sv
// Shared definitions for the req/ack handshake crossing (receive side).
// The sender side uses the same state encodings.
package cdc_hs_rx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_ACK  = ST_ACK
  } rx_state_e;

endpackage

// File: rtl/cdc_hs_rx_s.sv
// Two-flop synchronizer. Deliberately has no reset: after reset the
// input is flushed through within two clock edges.
module s #(
  parameter int W = 1
) (
  input  logic         c,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops to resolve metastability on the async input.
  always_ff @(posedge c) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive side of a four-phase req/ack crossing. Captures the sender's
// held word when synchronized req rises, offers it on valid/ready, then
// acknowledges and waits for req to fall before arming for the next word.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ack low, waiting for synchronized req to rise
//   S_HOLD | word captured, q_valid high, waiting for consumer
//   S_ACK  | ack high, waiting for synchronized req to fall
module cdc_hs_rx
  import cdc_hs_rx_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          c,
  input  logic          rst,
  input  logic          req,
  input  logic [W-1:0]  d,
  output logic          ack,
  output logic [W-1:0]  q,
  output logic          q_valid,
  input  logic          q_ready,
  output logic          err,
  input  logic          err_clr,
  output logic [CW-1:0] xfer_cnt
);

  logic      req_s;
  rx_state_e state;
  rx_state_e state_nxt;
  logic      capture;
  logic      accept;
  logic      release_ack;
  logic      err_set;

  s #(.W(1)) u_req_sync (
    .c (c),
    .d (req),
    .q (req_s)
  );

  // State register.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and single-cycle datapath strobes.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    accept      = 1'b0;
    release_ack = 1'b0;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_s) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Sender dropped req before seeing ack; flag it but still finish.
        err_set = ~req_s;
        // q_valid is always high here, so q_ready alone completes the accept.
        if (q_ready) begin
          accept    = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          release_ack = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture register, handshake outputs and transfer counter.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      q        <= '0;
      q_valid  <= 1'b0;
      ack      <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (capture) begin
        q       <= d;
        q_valid <= 1'b1;
      end else if (accept) begin
        q_valid <= 1'b0;
      end
      if (accept) begin
        ack      <= 1'b1;
        xfer_cnt <= xfer_cnt + CW'(1);
      end else if (release_ack) begin
        ack <= 1'b0;
      end
    end
  end

  // Sticky error flag; a fresh error beats a simultaneous clear.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Directed bench for cdc_hs_rx: reset, latency, backpressure, protocol
// error, async reset, back-to-back and random-phase transfers.
module tb_cdc_hs_rx;

  logic        c = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] d;
  logic        q_ready;
  logic        err_clr;
  logic        ack, q_valid, err;
  logic [31:0] q;
  logic [15:0] xfer_cnt;
  logic        ack4, q_valid4, err4;
  logic [31:0] q4;
  logic [3:0]  xfer_cnt4;

  int          checks = 0;
  int          errors = 0;
  int          n_xfer = 0;
  bit          rdy_rand = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    int          ready_dly;
    logic [31:0] d_late;
  } vec_t;

  vec_t vecs[5];

  cdc_hs_rx #(.W(32), .CW(16)) dut (
    .c(c), .rst(rst), .req(req), .d(d), .ack(ack), .q(q), .q_valid(q_valid),
    .q_ready(q_ready), .err(err), .err_clr(err_clr), .xfer_cnt(xfer_cnt)
  );

  cdc_hs_rx #(.W(32), .CW(4)) dut4 (
    .c(c), .rst(rst), .req(req), .d(d), .ack(ack4), .q(q4), .q_valid(q_valid4),
    .q_ready(q_ready), .err(err4), .err_clr(err_clr), .xfer_cnt(xfer_cnt4)
  );

  always #5 c = ~c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int k = 0;
    while (ack !== lvl && k < 60) begin
      tick();
      k++;
    end
    chk(nm, ack, lvl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    q_ready = 1'b0;
    err_clr = 1'b0;
    exp_q.delete();
    n_xfer = 0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic apply_vec(input vec_t v);
    d = v.data;
    q_ready = 1'b0;
    exp_q.push_back(v.data);
    req = 1'b1;
    tick(3);
    chk("vec_cap_valid", q_valid, 1);
    chk("vec_cap_q", q, v.data);
    d = v.d_late;
    for (int i = 0; i < v.ready_dly; i++) begin
      tick();
      chk("vec_hold_valid", q_valid, 1);
      chk("vec_hold_q", q, v.data);
      chk("vec_hold_ack", ack, 0);
    end
    q_ready = 1'b1;
    tick();
    n_xfer++;
    chk("vec_ack_rise", ack, 1);
    chk("vec_valid_drop", q_valid, 0);
    chk("vec_cnt", xfer_cnt, n_xfer[15:0]);
    q_ready = 1'b0;
    req = 1'b0;
    tick(2);
    chk("vec_ack_still", ack, 1);
    tick();
    chk("vec_ack_fall", ack, 0);
  endtask

  task automatic send(input logic [31:0] data, input bit rand_phase, input bit check_lat);
    int  k = 0;
    time t_req;
    time t_e = 0;
    if (rand_phase) #($urandom_range(0, 8));
    d = data;
    exp_q.push_back(data);
    req = 1'b1;
    t_req = $time;
    while (q_valid !== 1'b1 && k < 20) begin
      @(posedge c);
      t_e = $time;
      #1;
      k++;
    end
    if (check_lat)
      chk("cap_latency_2to3", (q_valid === 1'b1 && t_e >= t_req + 20 && t_e <= t_req + 30), 1);
    wait_ack(1'b1, "xfer_ack_rise");
    n_xfer++;
    if (rand_phase) #($urandom_range(0, 8));
    req = 1'b0;
    wait_ack(1'b0, "xfer_ack_fall");
  endtask

  // Scoreboard: every accepted word must be the next expected one.
  always @(posedge c) begin
    if (!rst && q_valid && q_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h required=none at %0t", q, $time);
      end else begin
        chk("rx_word", q, exp_q.pop_front());
      end
    end
  end

  // Random consumer backpressure when enabled.
  always @(posedge c) begin
    #1;
    if (rdy_rand) q_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{32'h0000_0001, 0,  32'h0000_0000},
      '{32'hFFFF_FFFF, 1,  32'h0000_0000},
      '{32'h1357_9BDF, 20, 32'h1234_5678},
      '{32'h8000_0000, 3,  32'hFFFF_FFFF},
      '{32'h0000_0000, 5,  32'hA5A5_A5A5}
    };
    rst = 1'b1;
    req = 1'b0;
    d = '0;
    q_ready = 1'b0;
    err_clr = 1'b0;
    tick(3);
    chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst4_all", {ack4, q_valid4, err4, q4, xfer_cnt4}, 0);
    rst = 1'b0;
    tick(2);

    // Basic transfer with q_ready tied high.
    q_ready = 1'b1;
    d = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    req = 1'b1;
    tick(2);
    chk("basic_valid_early", q_valid, 0);
    tick();
    chk("basic_valid", q_valid, 1);
    chk("basic_q", q, 32'hDEAD_BEEF);
    chk("basic_ack_low", ack, 0);
    tick();
    n_xfer++;
    chk("basic_valid_1cyc", q_valid, 0);
    chk("basic_ack", ack, 1);
    tick(5);
    req = 1'b0;
    tick(2);
    chk("basic_ack_hold", ack, 1);
    tick();
    chk("basic_ack_fall", ack, 0);
    chk("basic_cnt", xfer_cnt, 1);
    q_ready = 1'b0;

    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Protocol error: req dropped while the word is still held.
    d = 32'hA5A5_5A5A;
    exp_q.push_back(32'hA5A5_5A5A);
    req = 1'b1;
    tick(3);
    chk("perr_valid", q_valid, 1);
    req = 1'b0;
    tick(2);
    chk("perr_err_early", err, 0);
    tick();
    chk("perr_err_set", err, 1);
    chk("perr_still_valid", q_valid, 1);
    err_clr = 1'b1;
    tick();
    chk("perr_clr_vs_new", err, 1);
    err_clr = 1'b0;
    q_ready = 1'b1;
    tick();
    n_xfer++;
    chk("perr_ack", ack, 1);
    chk("perr_delivered", q_valid, 0);
    q_ready = 1'b0;
    tick();
    chk("perr_ack_pulse", ack, 0);
    chk("perr_sticky", err, 1);
    chk("perr_cnt", xfer_cnt, n_xfer[15:0]);
    err_clr = 1'b1;
    tick();
    chk("perr_cleared", err, 0);
    err_clr = 1'b0;

    // Asynchronous reset while holding a word.
    d = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    req = 1'b1;
    tick(3);
    chk("arst_pre_valid", q_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", q_valid, 0);
    chk("arst_ack", ack, 0);
    chk("arst_q", q, 0);
    chk("arst_cnt", xfer_cnt, 0);
    chk("arst_cnt4", xfer_cnt4, 0);
    exp_q.delete();
    n_xfer = 0;
    req = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    apply_vec(vecs[3]);

    // Back-to-back transfers with random consumer readiness.
    do_reset();
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      if (i == 15) begin
        chk("wrap16_cnt", xfer_cnt, 16);
        chk("wrap16_cnt4", xfer_cnt4, 0);
      end
    end
    chk("b2b_cnt", xfer_cnt, 300);
    chk("b2b_cnt4", xfer_cnt4, 4'd12);

    // Random req phase against the clock.
    for (int i = 0; i < 1000; i++) send($urandom, 1'b1, 1'b1);
    rdy_rand = 1'b0;
    tick(3);
    chk("all_words_rx", exp_q.size(), 0);
    chk("final_cnt", xfer_cnt, n_xfer[15:0]);
    chk("final_cnt4", xfer_cnt4, n_xfer[3:0]);
    chk("final_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
